acc_drain: RTL and testbench

//  Read-side engine for the accumulator BRAM: walks rows, requantizes each 16-lane x 20-bit partial-sum row
//  to 16 x 8-bit, streams rows to the unified-buffer writer over valid/ready. Sits between accumulator read port
//  (enb/addrb/doutb) and the UB write path; launched by the top-level controller once a tile's accumulation ends.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/acc_requant.sv | 47 ++++
 rtl/acc_drain.sv | 152 +++++++++++++++
 tb/tb_acc_drain.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and types for the accumulator / unified-buffer datapath.
//   DATA_SIZE : accumulator lane width (signed partial sums)
//   DATA_NUM  : lanes per accumulator / output row
//   OUT_SIZE  : requantized output lane width (signed)
//   RAM_DEPTH : accumulator rows, ADDR_W bits of row address
//   acc_row_t : one packed accumulator row, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   out_row_t : one packed output row, lane i at [i*OUT_SIZE +: OUT_SIZE]
package tpu_pkg;
   localparam int DATA_SIZE = 20;
   localparam int DATA_NUM  = 16;
   localparam int OUT_SIZE  = 8;
   localparam int RAM_DEPTH = 16;
   localparam int ADDR_W    = $clog2(RAM_DEPTH);

   typedef logic [DATA_NUM*DATA_SIZE-1:0] acc_row_t;
   typedef logic [DATA_NUM*OUT_SIZE-1:0]  out_row_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_FLUSH,
      ST_DONE
   } drain_state_t;
endpackage

// File: rtl/acc_requant.sv
// Single-lane requantizer: round-half-up arithmetic right shift of a signed
// partial sum, then saturation to the signed output range.
// Build option: RELU_EN -- when defined, negative inputs are clamped to zero
// before rounding, so the output range becomes 0..127.
// Ports:
//   x     in  DATA_SIZE  signed accumulator lane
//   shift in  5          right-shift amount, 0..19 (0 = pass through)
//   y     out OUT_SIZE   signed requantized lane
module acc_requant
   import tpu_pkg::*;
(
   input  logic signed [DATA_SIZE-1:0] x,
   input  logic        [4:0]           shift,
   output logic signed [OUT_SIZE-1:0]  y
);
   localparam logic signed [DATA_SIZE:0] SAT_MAX = 127;
   localparam logic signed [DATA_SIZE:0] SAT_MIN = -128;

   // One extra bit keeps x + half from wrapping for the largest positive x.
   logic signed [DATA_SIZE:0] x_ext;
   logic signed [DATA_SIZE:0] half;
   logic signed [DATA_SIZE:0] sum;
   logic signed [DATA_SIZE:0] shifted;

   always_comb begin
      x_ext = {x[DATA_SIZE-1], x};
`ifdef RELU_EN
      if (x[DATA_SIZE-1]) begin
         x_ext = '0;
      end
`else
`endif
      half = '0;
      if (shift != 5'd0) begin
         half = (DATA_SIZE+1)'(1) << (shift - 5'd1);
      end
      sum     = x_ext + half;
      shifted = sum >>> shift;
      if (shifted > SAT_MAX) begin
         y = 8'sd127;
      end else if (shifted < SAT_MIN) begin
         y = -8'sd128;
      end else begin
         y = shifted[OUT_SIZE-1:0];
      end
   end
endmodule

// File: rtl/acc_drain.sv
// Accumulator drain engine: walks row_count accumulator rows starting at
// base_addr (wrapping modulo RAM_DEPTH), requantizes each row lane by lane and
// streams the result downstream over a valid/ready handshake.
// Build option: RELU_EN (passed to acc_requant) clamps negative lanes to zero.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start                 launch pulse, only honoured while idle
//   base_addr, row_count  first row and number of rows (0..RAM_DEPTH)
//   shift                 requantization right shift
//   busy, done            run in progress / one-cycle completion pulse
//   acc_enb, acc_addrb    accumulator read port request
//   acc_doutb             accumulator read data (one cycle after acc_enb)
//   out_valid, out_ready  output handshake
//   out_data, out_last    requantized row and final-row marker
module acc_drain
   import tpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   row_count,
   input  logic [4:0]        shift,
   output logic              busy,
   output logic              done,
   output logic              acc_enb,
   output logic [ADDR_W-1:0] acc_addrb,
   input  acc_row_t          acc_doutb,
   output logic              out_valid,
   input  logic              out_ready,
   output out_row_t          out_data,
   output logic              out_last
);
   localparam logic [ADDR_W:0] ISSUE_ONE = 1;

   drain_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] base_reg;
   logic [ADDR_W:0]   count_reg;
   logic [4:0]        shift_reg;
   logic [ADDR_W:0]   issued_reg;
   logic              in_flight_reg;
   logic              in_flight_last_reg;

   // Two-entry output FIFO; depth two is enough to cover the read latency
   // and keep one row per cycle flowing.
   out_row_t          fifo_data_reg [2];
   logic              fifo_last_reg [2];
   logic              wr_ptr_reg;
   logic              rd_ptr_reg;
   logic [1:0]        fifo_count_reg;

   out_row_t          req_row;
   logic              pop;
   logic [1:0]        occupancy;
   logic              is_last_issue;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_NUM; gi++) begin : g_lane
         acc_requant u_requant (
            .x     (acc_doutb[gi*DATA_SIZE +: DATA_SIZE]),
            .shift (shift_reg),
            .y     (req_row[gi*OUT_SIZE +: OUT_SIZE])
         );
      end
   endgenerate

   assign out_valid = (fifo_count_reg != 2'd0);
   assign out_data  = fifo_data_reg[rd_ptr_reg];
   assign out_last  = out_valid & fifo_last_reg[rd_ptr_reg];
   assign pop       = out_valid & out_ready;

   // Rows committed to the FIFO (stored or in flight) once this cycle's pop
   // is retired; a new read is only issued while that leaves a free slot.
   assign occupancy     = fifo_count_reg + {1'b0, in_flight_reg} - {1'b0, pop};
   assign is_last_issue = ((issued_reg + ISSUE_ONE) == count_reg);
   assign acc_enb       = (state_reg == ST_READ) && (issued_reg != count_reg) &&
                          (occupancy < 2'd2);
   assign acc_addrb     = base_reg + issued_reg[ADDR_W-1:0];

   assign busy = (state_reg != ST_IDLE);
   assign done = (state_reg == ST_DONE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = (row_count != '0) ? ST_READ : ST_FLUSH;
            end
         end
         ST_READ: begin
            if (issued_reg == count_reg) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Leave as the final row is accepted so done follows the last
            // handshake by exactly one cycle.
            if (((fifo_count_reg - {1'b0, pop}) == 2'd0) && !in_flight_reg) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg          <= ST_IDLE;
         base_reg           <= '0;
         count_reg          <= '0;
         shift_reg          <= '0;
         issued_reg         <= '0;
         in_flight_reg      <= 1'b0;
         in_flight_last_reg <= 1'b0;
         wr_ptr_reg         <= 1'b0;
         rd_ptr_reg         <= 1'b0;
         fifo_count_reg     <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_reg[i] <= '0;
            fifo_last_reg[i] <= 1'b0;
         end
      end else begin
         state_reg <= state_next;
         if ((state_reg == ST_IDLE) && start) begin
            base_reg   <= base_addr;
            count_reg  <= row_count;
            shift_reg  <= shift;
            issued_reg <= '0;
         end else if (acc_enb) begin
            issued_reg <= issued_reg + ISSUE_ONE;
         end
         in_flight_reg      <= acc_enb;
         in_flight_last_reg <= acc_enb & is_last_issue;
         if (in_flight_reg) begin
            fifo_data_reg[wr_ptr_reg] <= req_row;
            fifo_last_reg[wr_ptr_reg] <= in_flight_last_reg;
            wr_ptr_reg                <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         fifo_count_reg <= fifo_count_reg + {1'b0, in_flight_reg} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_acc_drain.sv
// Directed testbench for acc_drain with a behavioural accumulator read port.
module tb_acc_drain;
   import tpu_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   row_count;
   logic [4:0]        shift;
   logic              busy, done, acc_enb;
   logic [ADDR_W-1:0] acc_addrb;
   acc_row_t          acc_doutb = '0;
   logic              out_valid, out_ready;
   out_row_t          out_data;
   logic              out_last;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   acc_row_t mem [RAM_DEPTH];

   // run_drain observations
   out_row_t rx_data[$];
   bit       rx_last[$];
   int       rx_cyc[$];
   int       addr_log[$];
   int       start_cyc, first_valid_cyc, done_cyc, done_cnt;
   int       credit_viol, stable_viol, timed_out;
   logic     busy_at_start, busy_at_end;

   acc_drain dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .row_count(row_count), .shift(shift), .busy(busy), .done(done),
      .acc_enb(acc_enb), .acc_addrb(acc_addrb), .acc_doutb(acc_doutb),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (acc_enb) acc_doutb <= mem[acc_addrb];

   function automatic out_row_t ramp_row(input int a);
      out_row_t r;
      for (int i = 0; i < DATA_NUM; i++) r[i*OUT_SIZE +: OUT_SIZE] = 8'(i + a);
      return r;
   endfunction

   task automatic fill_ramp();
      for (int a = 0; a < RAM_DEPTH; a++)
         for (int i = 0; i < DATA_NUM; i++) mem[a][i*DATA_SIZE +: DATA_SIZE] = 20'(i + a);
   endtask

   // Launches one run and records everything observed; comparisons are made by the callers.
   task automatic run_drain(input int b, input int n, input int sh, input bit rand_ready, input bit restart);
      int enb_tot, hs_tot, post;
      bit prev_stall;
      out_row_t prev_data;
      logic prev_last;
      rx_data.delete(); rx_last.delete(); rx_cyc.delete(); addr_log.delete();
      first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; credit_viol = 0; stable_viol = 0;
      timed_out = 1; enb_tot = 0; hs_tot = 0; post = 0; prev_stall = 0;
      prev_data = '0; prev_last = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = b[ADDR_W-1:0]; row_count = n[ADDR_W:0]; shift = sh[4:0]; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; base_addr = ~base_addr; row_count = 5'd9; shift = 5'd7;
      start_cyc = cyc;
      for (int k = 0; k < 400; k++) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         start = restart && (k == 1);
         #1;
         if (k == 0) busy_at_start = busy;
         if (acc_enb) begin
            addr_log.push_back(int'(acc_addrb));
            if (enb_tot - hs_tot - ((out_valid && out_ready) ? 1 : 0) >= 2) credit_viol++;
            enb_tot++;
         end
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) stable_viol++;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            rx_data.push_back(out_data); rx_last.push_back(out_last); rx_cyc.push_back(cyc);
            hs_tot++;
         end
         prev_stall = out_valid && !out_ready; prev_data = out_data; prev_last = out_last;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0) post++;
         @(negedge clk);
         if (post >= 3) begin
            timed_out = 0;
            break;
         end
      end
      start = 1'b0;
      #1 busy_at_end = busy;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; base_addr = '0; row_count = '0; shift = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (acc_enb !== 1'b0) begin bad++; $display("FAIL reset_enb got=%b want=0", acc_enb); end
      total++; if (acc_addrb !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", acc_addrb); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
      @(negedge clk); reset_n = 1'b1;
      $display("reset: checked idle outputs");
   endtask

   task automatic test_basic();
      fill_ramp();
      run_drain(0, 4, 0, 1'b0, 1'b0);
      total++; if (timed_out !== 0) begin bad++; $display("FAIL t1_timeout got=%0d want=0", timed_out); end
      total++; if (busy_at_start !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b want=1", busy_at_start); end
      total++; if (rx_data.size() !== 4) begin bad++; $display("FAIL t1_rows got=%0d want=4", rx_data.size()); end
      for (int r = 0; r < 4; r++) begin
         out_row_t got = (r < rx_data.size()) ? rx_data[r] : '0;
         bit lst = (r < rx_last.size()) ? rx_last[r] : 1'b0;
         int gc = (r < rx_cyc.size()) ? rx_cyc[r] : -1;
         total++; if (got !== ramp_row(r)) begin bad++; $display("FAIL t1_data%0d got=%h want=%h", r, got, ramp_row(r)); end
         total++; if (lst !== (r == 3)) begin bad++; $display("FAIL t1_last%0d got=%b want=%b", r, lst, r == 3); end
         total++; if (gc !== start_cyc + 2 + r) begin bad++; $display("FAIL t1_cycle%0d got=%0d want=%0d", r, gc - start_cyc, 2 + r); end
         $display("t1 row %0d data=%h last=%b", r, got, lst);
      end
      total++; if (first_valid_cyc !== start_cyc + 2) begin bad++; $display("FAIL t1_first_valid got=%0d want=2", first_valid_cyc - start_cyc); end
      total++; if (done_cyc !== start_cyc + 6) begin bad++; $display("FAIL t1_done_cycle got=%0d want=6", done_cyc - start_cyc); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL t1_done_pulses got=%0d want=1", done_cnt); end
      total++; if (busy_at_end !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%b want=0", busy_at_end); end
   endtask

   task automatic test_wrap();
      int want_addr[4] = '{14, 15, 0, 1};
      fill_ramp();
      run_drain(14, 4, 0, 1'b0, 1'b0);
      total++; if (addr_log.size() !== 4) begin bad++; $display("FAIL t2_reads got=%0d want=4", addr_log.size()); end
      for (int r = 0; r < 4; r++) begin
         int ga = (r < addr_log.size()) ? addr_log[r] : -1;
         out_row_t got = (r < rx_data.size()) ? rx_data[r] : '0;
         total++; if (ga !== want_addr[r]) begin bad++; $display("FAIL t2_addr%0d got=%0d want=%0d", r, ga, want_addr[r]); end
         total++; if (got !== ramp_row(want_addr[r])) begin bad++; $display("FAIL t2_data%0d got=%h want=%h", r, got, ramp_row(want_addr[r])); end
         $display("t2 row %0d addr=%0d data=%h", r, ga, got);
      end
   endtask

   task automatic test_requant();
      int in_v[16] = '{524287, 24, 23, -300, -524288, -24, 127, 128, -128, -129, 0, 0, 0, 0, 0, 0};
      int shifts[3] = '{4, 0, 19};
`ifdef RELU_EN
      int e4[16]  = '{127, 2, 1, 0, 0, 0, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0};
      int e0[16]  = '{127, 24, 23, 0, 0, 0, 127, 127, 0, 0, 0, 0, 0, 0, 0, 0};
      int e19[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
      int e4[16]  = '{127, 2, 1, -19, -128, -1, 8, 8, -8, -8, 0, 0, 0, 0, 0, 0};
      int e0[16]  = '{127, 24, 23, -128, -128, -24, 127, 127, -128, -128, 0, 0, 0, 0, 0, 0};
      int e19[16] = '{1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
      for (int i = 0; i < DATA_NUM; i++) mem[3][i*DATA_SIZE +: DATA_SIZE] = 20'(in_v[i]);
      for (int s = 0; s < 3; s++) begin
         out_row_t want, got;
         for (int i = 0; i < DATA_NUM; i++)
            want[i*OUT_SIZE +: OUT_SIZE] = (s == 0) ? 8'(e4[i]) : (s == 1) ? 8'(e0[i]) : 8'(e19[i]);
         run_drain(3, 1, shifts[s], 1'b0, 1'b0);
         got = (rx_data.size() > 0) ? rx_data[0] : '0;
         total++; if (got !== want) begin bad++; $display("FAIL t3_shift%0d got=%h want=%h", shifts[s], got, want); end
         total++; if (rx_last.size() !== 1 || rx_last[0] !== 1'b1) begin bad++; $display("FAIL t3_last%0d got=%0d rows want=1 last row", shifts[s], rx_last.size()); end
         total++; if (done_cnt !== 1) begin bad++; $display("FAIL t3_done%0d got=%0d want=1", shifts[s], done_cnt); end
         $display("t3 shift=%0d data=%h", shifts[s], got);
      end
   endtask

   task automatic test_backpressure();
      int last_hs;
      fill_ramp();
      run_drain(5, 8, 0, 1'b1, 1'b0);
      total++; if (timed_out !== 0) begin bad++; $display("FAIL t4_timeout got=%0d want=0", timed_out); end
      total++; if (rx_data.size() !== 8) begin bad++; $display("FAIL t4_rows got=%0d want=8", rx_data.size()); end
      total++; if (addr_log.size() !== 8) begin bad++; $display("FAIL t4_reads got=%0d want=8", addr_log.size()); end
      for (int r = 0; r < 8; r++) begin
         out_row_t got = (r < rx_data.size()) ? rx_data[r] : '0;
         bit lst = (r < rx_last.size()) ? rx_last[r] : 1'b0;
         total++; if (got !== ramp_row(5 + r)) begin bad++; $display("FAIL t4_data%0d got=%h want=%h", r, got, ramp_row(5 + r)); end
         total++; if (lst !== (r == 7)) begin bad++; $display("FAIL t4_last%0d got=%b want=%b", r, lst, r == 7); end
         $display("t4 row %0d data=%h last=%b", r, got, lst);
      end
      total++; if (stable_viol !== 0) begin bad++; $display("FAIL t4_stall_stable got=%0d want=0", stable_viol); end
      total++; if (credit_viol !== 0) begin bad++; $display("FAIL t4_credit got=%0d want=0", credit_viol); end
      last_hs = (rx_cyc.size() > 0) ? rx_cyc[rx_cyc.size()-1] : -10;
      total++; if (done_cyc !== last_hs + 1) begin bad++; $display("FAIL t4_done_after_last got=%0d want=1", done_cyc - last_hs); end
   endtask

   task automatic test_empty_and_busy();
      run_drain(2, 0, 0, 1'b0, 1'b0);
      total++; if (addr_log.size() !== 0) begin bad++; $display("FAIL t5_reads got=%0d want=0", addr_log.size()); end
      total++; if (first_valid_cyc !== -1) begin bad++; $display("FAIL t5_valid got=%0d want=-1", first_valid_cyc); end
      total++; if (done_cyc !== start_cyc + 1) begin bad++; $display("FAIL t5_done_cycle got=%0d want=1", done_cyc - start_cyc); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL t5_done_pulses got=%0d want=1", done_cnt); end
      $display("t5 empty run done at +%0d", done_cyc - start_cyc);
      fill_ramp();
      run_drain(0, 3, 0, 1'b0, 1'b1);
      total++; if (rx_data.size() !== 3) begin bad++; $display("FAIL t5_restart_rows got=%0d want=3", rx_data.size()); end
      for (int r = 0; r < 3; r++) begin
         out_row_t got = (r < rx_data.size()) ? rx_data[r] : '0;
         total++; if (got !== ramp_row(r)) begin bad++; $display("FAIL t5_data%0d got=%h want=%h", r, got, ramp_row(r)); end
      end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL t5_restart_done got=%0d want=1", done_cnt); end
      $display("t5 start while busy: rows=%0d", rx_data.size());
   endtask

   task automatic test_reset_midrun();
      int hs;
      bit saw_done;
      fill_ramp();
      hs = 0; saw_done = 0;
      @(negedge clk);
      start = 1'b1; base_addr = '0; row_count = 5'd8; shift = '0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40 && hs < 3; k++) begin
         #1;
         if (out_valid && out_ready) hs++;
         if (done) saw_done = 1;
         @(negedge clk);
      end
      #1;
      total++; if (hs !== 3) begin bad++; $display("FAIL t6_pre_rows got=%0d want=3", hs); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t6_pre_valid got=%b want=1", out_valid); end
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b want=0", busy); end
      total++; if (acc_enb !== 1'b0) begin bad++; $display("FAIL t6_enb got=%b want=0", acc_enb); end
      total++; if (acc_addrb !== '0) begin bad++; $display("FAIL t6_addr got=%0d want=0", acc_addrb); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t6_valid got=%b want=0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL t6_last got=%b want=0", out_last); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL t6_data got=%h want=0", out_data); end
      for (int k = 0; k < 3; k++) begin
         if (done) saw_done = 1;
         @(negedge clk);
         #1;
      end
      if (done) saw_done = 1;
      total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL t6_no_done got=%b want=0", saw_done); end
      reset_n = 1'b1;
      $display("t6 reset after %0d rows", hs);
      run_drain(6, 2, 0, 1'b0, 1'b0);
      total++; if (rx_data.size() !== 2) begin bad++; $display("FAIL t6_rerun_rows got=%0d want=2", rx_data.size()); end
      for (int r = 0; r < 2; r++) begin
         out_row_t got = (r < rx_data.size()) ? rx_data[r] : '0;
         total++; if (got !== ramp_row(6 + r)) begin bad++; $display("FAIL t6_rerun%0d got=%h want=%h", r, got, ramp_row(6 + r)); end
      end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL t6_rerun_done got=%0d want=1", done_cnt); end
   endtask

   initial begin
      for (int a = 0; a < RAM_DEPTH; a++) mem[a] = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_requant();
      test_backpressure();
      test_empty_and_busy();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
